// File: rtl/row_frame_ctrl_pkg.sv
// Shared types and constants for the row framebuffer controller and its scanner.
// Enum literals carry a prefix so they never collide with the BLANK/DWELL timing parameters.
package frame_pkg;

   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int ROW_W = $clog2(ROWS);

   typedef enum logic {
      SCAN_BLANK,
      SCAN_SHOW
   } scan_state_e;

   typedef enum logic {
      CLR_IDLE,
      CLR_SWEEP
   } clr_state_e;

   function automatic logic [ROWS-1:0] rowOneHot(input logic [ROW_W-1:0] row);
      return ROWS'(1) << row;
   endfunction

endpackage

// File: rtl/row_frame_ctrl_scanner.sv
// Row scanner: alternates BLANK and SHOW phases, walking the row pointer 0..7 and
// snapshotting the addressed framebuffer row on every SHOW entry.
module row_scanner
   import frame_pkg::*;
#(
   parameter int DWELL = 1024,
   parameter int BLANK = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic [ROW_W-1:0] rd_row,
   input  logic [COLS-1:0]  rd_data,
   output logic [ROWS-1:0]  row_sel,
   output logic [COLS-1:0]  col_data,
   output logic             frame_tick
);

   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0] DWELL_PREV = (DWELL > 1) ? CW'(DWELL - 2) : '0;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   scan_state_e      state_q;
   logic [CW-1:0]    cnt_q;
   logic [ROW_W-1:0] ptr_q;
   logic [ROWS-1:0]  rowSel_q;
   logic [COLS-1:0]  colData_q;
   logic             tick_q;
   logic             tick_d;

   // The tick is registered, so it is raised one edge early: when the coming cycle
   // will be the final SHOW cycle of the last row.
   always_comb begin
      tick_d = 1'b0;
      if (ptr_q == LAST_ROW) begin
         if (DWELL == 1)
            tick_d = (state_q == SCAN_BLANK) && (cnt_q == BLANK_LAST);
         else
            tick_d = (state_q == SCAN_SHOW) && (cnt_q == DWELL_PREV);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= SCAN_BLANK;
         cnt_q     <= '0;
         ptr_q     <= '0;
         rowSel_q  <= '0;
         colData_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         tick_q <= tick_d;
         case (state_q)
            SCAN_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_q   <= SCAN_SHOW;
                  cnt_q     <= '0;
                  rowSel_q  <= rowOneHot(ptr_q);
                  colData_q <= rd_data;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            SCAN_SHOW: begin
               if (cnt_q == DWELL_LAST) begin
                  state_q   <= SCAN_BLANK;
                  cnt_q     <= '0;
                  rowSel_q  <= '0;
                  colData_q <= '0;
                  ptr_q     <= ptr_q + ROW_W'(1);
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
         endcase
      end
   end

   assign rd_row     = ptr_q;
   assign row_sel    = rowSel_q;
   assign col_data   = colData_q;
   assign frame_tick = tick_q;

endmodule

// File: rtl/row_frame_ctrl.sv
// Framebuffer owner: applies row writes, runs the 8-cycle clear sweep, parks colliding
// writes in a one-deep pending register, and feeds the row scanner.
module row_frame_ctrl
   import frame_pkg::*;
#(
   parameter int DWELL = 1024,
   parameter int BLANK = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_strobe,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COLS-1:0]  wr_val,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic [ROWS-1:0]  row_sel,
   output logic [COLS-1:0]  col_data,
   output logic             frame_tick
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   logic [COLS-1:0]  fb_q [ROWS];
   clr_state_e       clrState_q;
   logic [ROW_W-1:0] sweepIdx_q;
   logic             clrBusy_q;
   logic             pendValid_q;
   logic [ROW_W-1:0] pendRow_q;
   logic [COLS-1:0]  pendVal_q;
   logic [ROW_W-1:0] rdRow;
   logic [COLS-1:0]  rdData;

   // Writes reach the framebuffer only in IDLE with no clear request; otherwise they
   // are parked. A parked write drains first so a same-cycle write to that row wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clrState_q  <= CLR_IDLE;
         sweepIdx_q  <= '0;
         clrBusy_q   <= 1'b0;
         pendValid_q <= 1'b0;
         pendRow_q   <= '0;
         pendVal_q   <= '0;
         for (int i = 0; i < ROWS; i++)
            fb_q[i] <= '0;
      end else begin
         case (clrState_q)
            CLR_IDLE: begin
               if (clr_req) begin
                  clrState_q <= CLR_SWEEP;
                  sweepIdx_q <= '0;
                  clrBusy_q  <= 1'b1;
                  if (wr_strobe) begin
                     pendValid_q <= 1'b1;
                     pendRow_q   <= wr_row;
                     pendVal_q   <= wr_val;
                  end
               end else begin
                  if (pendValid_q) begin
                     fb_q[pendRow_q] <= pendVal_q;
                     pendValid_q     <= 1'b0;
                  end
                  if (wr_strobe)
                     fb_q[wr_row] <= wr_val;
               end
            end
            CLR_SWEEP: begin
               fb_q[sweepIdx_q] <= '0;
               sweepIdx_q       <= sweepIdx_q + ROW_W'(1);
               if (sweepIdx_q == LAST_ROW) begin
                  clrState_q <= CLR_IDLE;
                  clrBusy_q  <= 1'b0;
               end
               if (wr_strobe) begin
                  pendValid_q <= 1'b1;
                  pendRow_q   <= wr_row;
                  pendVal_q   <= wr_val;
               end
            end
         endcase
      end
   end

   assign rdData   = fb_q[rdRow];
   assign clr_busy = clrBusy_q;

   row_scanner #(
      .DWELL (DWELL),
      .BLANK (BLANK)
   ) uScanner (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_row     (rdRow),
      .rd_data    (rdData),
      .row_sel    (row_sel),
      .col_data   (col_data),
      .frame_tick (frame_tick)
   );

endmodule

// File: tb/tb_row_frame_ctrl.sv
// Bench for row_frame_ctrl: a cycle-position/framebuffer model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_row_frame_ctrl;

   localparam int DWELL = 4;
   localparam int BLANK = 2;
   localparam int PHASE = DWELL + BLANK;
   localparam int FRAME = 8 * PHASE;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_strobe;
   logic [2:0] wr_row;
   logic [7:0] wr_val;
   logic       clr_req;
   logic       clr_busy;
   logic [7:0] row_sel;
   logic [7:0] col_data;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;

   row_frame_ctrl #(
      .DWELL (DWELL),
      .BLANK (BLANK)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_strobe  (wr_strobe),
      .wr_row     (wr_row),
      .wr_val     (wr_val),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .row_sel    (row_sel),
      .col_data   (col_data),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model: phaseK counts edges since reset release; the screen position follows from it
   // arithmetically. The framebuffer is an array updated by the write/clear rules.
   logic [7:0] mfb [8];
   int         phaseK;
   int         sweepLeft;
   bit         mPendValid;
   logic [2:0] mPendRow;
   logic [7:0] mPendVal;
   logic [7:0] expCol;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) mfb[i] = 8'h00;
         phaseK     = 0;
         sweepLeft  = 0;
         mPendValid = 0;
         mPendRow   = 3'd0;
         mPendVal   = 8'h00;
         expCol     = 8'h00;
      end else begin
         int nk;
         nk = phaseK + 1;
         if ((nk % PHASE) == BLANK) expCol = mfb[(nk % FRAME) / PHASE];
         if (sweepLeft > 0) begin
            mfb[8 - sweepLeft] = 8'h00;
            sweepLeft--;
            if (wr_strobe) begin mPendValid = 1; mPendRow = wr_row; mPendVal = wr_val; end
         end else if (clr_req) begin
            sweepLeft = 8;
            if (wr_strobe) begin mPendValid = 1; mPendRow = wr_row; mPendVal = wr_val; end
         end else begin
            if (mPendValid) mfb[mPendRow] = mPendVal;
            mPendValid = 0;
            if (wr_strobe) mfb[wr_row] = wr_val;
         end
         phaseK = nk;
      end
   end

   function automatic logic [7:0] modelRowSel(input int k);
      if ((k % PHASE) >= BLANK) return 8'(1 << ((k % FRAME) / PHASE));
      return 8'h00;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         checkOutput("resetRowSel", {24'h0, row_sel}, 32'h0);
         checkOutput("resetColData", {24'h0, col_data}, 32'h0);
         checkOutput("resetClrBusy", {31'h0, clr_busy}, 32'h0);
         checkOutput("resetFrameTick", {31'h0, frame_tick}, 32'h0);
      end else begin
         checkOutput("modelRowSel", {24'h0, row_sel}, {24'h0, modelRowSel(phaseK)});
         checkOutput("modelFrameTick", {31'h0, frame_tick}, {31'h0, (phaseK % FRAME) == FRAME - 1});
         checkOutput("modelClrBusy", {31'h0, clr_busy}, {31'h0, sweepLeft > 0});
         if (modelRowSel(phaseK) != 8'h00)
            checkOutput("modelColData", {24'h0, col_data}, {24'h0, expCol});
      end
   end

   task automatic applyStimulus(input bit doWrite, input logic [2:0] row, input logic [7:0] val, input bit doClear);
      @(posedge clk);
      #1;
      wr_strobe = doWrite;
      wr_row    = row;
      wr_val    = val;
      clr_req   = doClear;
      @(posedge clk);
      #1;
      wr_strobe = 1'b0;
      clr_req   = 1'b0;
   endtask

   // Waits for a fresh SHOW entry of the row so the snapshot postdates earlier writes.
   task automatic checkRow(input int row, input logic [7:0] expVal, input string name);
      logic [7:0] sel;
      bit         seen;
      sel  = 8'(1 << row);
      seen = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (row_sel != sel) begin seen = 1; break; end
      end
      if (seen) begin
         seen = 0;
         for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (row_sel == sel) begin seen = 1; break; end
         end
      end
      if (!seen) checkOutput({name, "Timeout"}, 32'h0, 32'h1);
      else       checkOutput(name, {24'h0, col_data}, {24'h0, expVal});
   endtask

   task automatic waitIdle(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!clr_busy) begin ok = 1; break; end
      end
      if (!ok) checkOutput({name, "Timeout"}, 32'h0, 32'h1);
      @(negedge clk);
   endtask

   task automatic waitTick(output int at, output bit ok);
      ok = 0;
      at = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (frame_tick) begin ok = 1; at = cycleCnt; break; end
      end
   endtask

   initial begin
      logic [7:0] seq [10];
      int         relCycle, tick1, tick2, busyCnt;
      bit         ok1, ok2;
      seq = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h02, 8'h02};

      reset_n   = 1'b0;
      wr_strobe = 1'b0;
      wr_row    = 3'd0;
      wr_val    = 8'h00;
      clr_req   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Scan order straight out of reset
      @(negedge clk);
      relCycle = cycleCnt;
      checkOutput("seqRowSel0", {24'h0, row_sel}, {24'h0, seq[0]});
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         checkOutput($sformatf("seqRowSel%0d", i), {24'h0, row_sel}, {24'h0, seq[i]});
         checkOutput($sformatf("seqColData%0d", i), {24'h0, col_data}, 32'h0);
      end

      waitTick(tick1, ok1);
      waitTick(tick2, ok2);
      if (!(ok1 && ok2)) checkOutput("frameTickTimeout", 32'h0, 32'h1);
      else begin
         checkOutput("firstTickCycle", tick1 - relCycle, 47);
         checkOutput("tickPeriod", tick2 - tick1, 48);
      end

      // Single direct write
      applyStimulus(1, 3'd3, 8'hA5, 0);
      checkRow(3, 8'hA5, "row3AfterWrite");
      checkRow(2, 8'h00, "row2Untouched");

      // Fill then one-cycle clear pulse
      for (int r = 0; r < 8; r++) applyStimulus(1, 3'(r), 8'hFF, 0);
      checkRow(7, 8'hFF, "row7Filled");
      applyStimulus(0, 3'd0, 8'h00, 1);
      busyCnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (clr_busy) busyCnt++;
      end
      checkOutput("clrBusyCycles", busyCnt, 8);
      for (int r = 0; r < 8; r++) checkRow(r, 8'h00, $sformatf("clearedRow%0d", r));

      // Two writes to row 0 during a sweep: last one wins
      for (int r = 1; r < 8; r++) applyStimulus(1, 3'(r), 8'h5A, 0);
      applyStimulus(0, 3'd0, 8'h00, 1);
      applyStimulus(1, 3'd0, 8'h11, 0);
      applyStimulus(1, 3'd0, 8'h22, 0);
      waitIdle("sweep2");
      checkRow(0, 8'h22, "pendRow0");
      for (int r = 1; r < 8; r++) checkRow(r, 8'h00, $sformatf("sweep2Row%0d", r));

      // Write coinciding with the clear request
      applyStimulus(1, 3'd5, 8'h3C, 1);
      waitIdle("sweep3");
      checkRow(5, 8'h3C, "sameCycleRow5");
      checkRow(4, 8'h00, "sameCycleRow4");

      // Reset in the middle of a sweep with a pending write parked
      applyStimulus(0, 3'd0, 8'h00, 1);
      applyStimulus(1, 3'd6, 8'h77, 0);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("midResetClrBusy", {31'h0, clr_busy}, 32'h0);
      checkOutput("midResetRowSel", {24'h0, row_sel}, 32'h0);
      checkOutput("midResetColData", {24'h0, col_data}, 32'h0);
      checkOutput("midResetFrameTick", {31'h0, frame_tick}, 32'h0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("postResetClrBusy", {31'h0, clr_busy}, 32'h0);
      checkRow(6, 8'h00, "pendingDiscarded");
      checkRow(5, 8'h00, "row5AfterReset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/row_frame_ctrl.md
# row_frame_ctrl

Owns the 8x8 row framebuffer between the game FSM and the LED matrix. Accepts row writes (`wr_strobe`/`wr_row`/`wr_val`) and clear requests from the game FSM, sequences a multi-cycle clear sweep, and continuously scans the framebuffer out to the matrix one row at a time with blanking between rows. Resolves collisions between writes and clears with a one-deep pending-write holding register.

## Interface
- `DWELL`, 1024, cycles each row is driven (>=1)
- `BLANK`, 4, all-rows-off cycles before each row (>=1)
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_strobe`  in  1  one-cycle write request
- `wr_row`  in  3  target row index, 0..7
- `wr_val`  in  8  row contents, bit i = column i lit
- `clr_req`  in  1  clear request, sampled every cycle
- `clr_busy`  out  1  clear sweep in progress
- `row_sel`  out  8  one-hot row enable, active-high; all-zero while blanking
- `col_data`  out  8  column data for the selected row
- `frame_tick`  out  1  one-cycle pulse at end of row 7's SHOW

## Operation
- Reset, asynchronous: framebuffer all 0; `row_sel`=0, `col_data`=0, `clr_busy`=0, `frame_tick`=0; pending register empty; scan in BLANK with row pointer 0 and counter 0; clear FSM IDLE.
- Clear FSM, states IDLE and SWEEP:
  - IDLE with `clr_req`=1 -> SWEEP with sweep index 0.
  - In SWEEP, clear `fb[idx]` each cycle and increment idx. After idx 7 -> IDLE.
  - `clr_req` asserted during SWEEP is ignored. If it is still high when SWEEP ends, IDLE immediately starts a new sweep on the next cycle.
- Writes:
  - IDLE, no `clr_req`, pending empty: `fb[wr_row] <= wr_val`.
  - `wr_strobe` while `clr_req`=1 in IDLE, or at any time during SWEEP: capture {`wr_row`, `wr_val`} into the pending register. A later write overwrites pending (last wins).
  - On the first IDLE cycle with `clr_req`=0 and pending full: apply pending to fb and empty it. A same-cycle new `wr_strobe` is applied after pending, so on the same row the new value wins.
- Scan FSM, states BLANK and SHOW:
  - BLANK: `row_sel`=0 for BLANK cycles, then -> SHOW.
  - On entry to SHOW, snapshot `fb[ptr]` into `col_data`. It is held constant for the whole SHOW, with no tearing.
  - SHOW: `row_sel`=1<<ptr for DWELL cycles, then -> BLANK and ptr increments, wrapping 7->0.
  - `frame_tick`=1 on the last SHOW cycle of ptr 7.
- Scan runs independently of clears and writes; it never stalls.

## Timing
- Direct write at edge t: visible in fb after edge t; shown at that row's next SHOW entry.
- Clear: `clr_req` sampled high at edge t. `clr_busy`=1 for exactly 8 cycles, t+1..t+8. Rows 0..7 are zeroed on edges t+1..t+8.
- Pending write lands on the first edge at which `clr_busy`=0 and `clr_req`=0.
- Frame period = 8*(DWELL+BLANK) cycles. `frame_tick` period is identical.
- All outputs are registered. No combinational input-to-output paths.
- Reset mid-sweep or with pending full: sweep aborted, pending discarded, all outputs go to reset values immediately.

## Structure
- Shared package `frame_pkg`:
  - constants `ROWS`=8, `COLS`=8
  - scan state enum {BLANK, SHOW}
  - clear state enum {IDLE, SWEEP}
- Sub-module `row_scanner`: scan FSM, dwell/blank counter, row pointer, `frame_tick`.
  - Reads a framebuffer row via a `rd_row`/`rd_data` port.
  - Framebuffer, clear FSM and pending logic stay in the top level.

## Test plan
- Reset, DWELL=4, BLANK=2: `row_sel` sequence 0,0,01,01,01,01,0,0,02,... `col_data`=0 throughout; `frame_tick` every 48 cycles.
- Write row 3=0xA5, no clear: at the next SHOW of row 3, `row_sel`=0x08 and `col_data`=0xA5; other rows stay 0.
- Fill all rows with 0xFF, pulse `clr_req` one cycle: `clr_busy` high exactly 8 cycles; all rows read 0x00 at the next frame.
- Clear started, then writes row 0=0x11 and row 0=0x22 during sweep: after `clr_busy` falls, row 0=0x22 and rows 1..7=0.
- `clr_req` and `wr_strobe` row 5=0x3C in the same cycle: sweep runs, then row 5=0x3C after the sweep.
- Assert `reset_n`=0 mid-sweep with pending full: outputs 0 at once; after release, no pending write is applied and `clr_busy`=0.
